mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF fetches and MEM loads/stores onto an 8-bit RAM.
// Define MEM_CTRL_IO_FULL_EN to add io_full_i back-pressure for stores to the IO window.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic [31:0] ram_addr_o,
  output logic [7:0]  ram_dout_o,
  output logic        ram_wr_o,
  input  logic [7:0]  ram_din_i
`ifdef MEM_CTRL_IO_FULL_EN
  ,
  input  logic        io_full_i
`endif
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d;

  logic        io_block;
  logic        accept_mem, accept_if;
  logic [2:0]  last_cnt;
  logic        txn_end;
  logic        addr_phase;
  logic [2:0]  cnt_m1;
  logic [1:0]  byte_idx;
  logic [2:0]  len_bytes;

`ifdef MEM_CTRL_IO_FULL_EN
  assign io_block = mem_req_i & mem_we_i & (mem_addr_i[17:16] == 2'b11) & io_full_i;
`else
  assign io_block = 1'b0;
`endif

  always_comb begin
    accept_mem = (state_q == StIdle) & mem_req_i & ~io_block;
    // A blocked store still owns the port: IF waits behind it.
    accept_if  = (state_q == StIdle) & ~mem_req_i & if_req_i;
    // Reads need one extra cycle for the registered RAM data to arrive.
    last_cnt   = we_q ? nbytes_q : nbytes_q + 3'd1;
    txn_end    = (cnt_q == last_cnt);
    addr_phase = (state_q != StIdle) && (cnt_q < nbytes_q);
    cnt_m1     = cnt_q - 3'd1;
    byte_idx   = cnt_m1[1:0];
    unique case (mem_len_i)
      2'd0:    len_bytes = 3'd1;
      2'd1:    len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept_mem) begin
          state_d = StMemBusy;
        end else if (accept_if) begin
          state_d = StIfBusy;
        end
      end
      StIfBusy: begin
        if (!if_req_i || txn_end) begin
          state_d = StIdle;
        end
      end
      StMemBusy: begin
        if (txn_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transaction datapath
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    nbytes_d = nbytes_q;
    we_d     = we_q;
    data_d   = data_q;
    if (state_q == StIdle) begin
      cnt_d = 3'd0;
      if (accept_mem) begin
        addr_d   = mem_addr_i;
        nbytes_d = len_bytes;
        we_d     = mem_we_i;
        data_d   = mem_we_i ? mem_wdata_i : 32'd0;
      end else if (accept_if) begin
        addr_d   = if_addr_i;
        nbytes_d = 3'd4;
        we_d     = 1'b0;
        data_d   = 32'd0;
      end
    end else begin
      cnt_d = (state_d == StIdle) ? 3'd0 : cnt_q + 3'd1;
      // Byte i arrives in busy cycle i+2, i.e. while cnt_q == i+1.
      if (!we_q && (cnt_q != 3'd0) && (cnt_q <= nbytes_q)) begin
        data_d[{byte_idx, 3'b000} +: 8] = ram_din_i;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q    <= 3'd0;
      addr_q   <= 32'd0;
      nbytes_q <= 3'd0;
      we_q     <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nbytes_q <= nbytes_d;
      we_q     <= we_d;
      data_q   <= data_d;
    end
  end

  // Output logic
  always_comb begin
    ram_addr_o  = addr_phase ? addr_q + {29'd0, cnt_q} : 32'd0;
    ram_wr_o    = (state_q == StMemBusy) && we_q && addr_phase;
    ram_dout_o  = ram_wr_o ? data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    if_done_o   = (state_q == StIfBusy) && txn_end && if_req_i;
    mem_done_o  = (state_q == StMemBusy) && txn_end;
    if_data_o   = if_done_o ? data_q : 32'd0;
    mem_rdata_o = (mem_done_o && !we_q) ? data_q : 32'd0;
    // Reset forces every output low, the stall requests included.
    stall_if_o  = if_req_i & ~if_done_o & ~rst_in;
    stall_mem_o = mem_req_i & ~mem_done_o & ~rst_in;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a registered-read byte RAM model.
// Exercises the MEM_CTRL_IO_FULL_EN path when that macro is defined.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, mem_req, mem_we, mem_done, stall_if, stall_mem, ram_wr;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_addr;
  logic [1:0]  mem_len;
  logic [7:0]  ram_dout, ram_din;
`ifdef MEM_CTRL_IO_FULL_EN
  logic        io_full;
`endif

  logic [7:0] ram [0:4095];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_data_o   (if_data),
    .if_done_o   (if_done),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_len_i   (mem_len),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_done_o  (mem_done),
    .stall_if_o  (stall_if),
    .stall_mem_o (stall_mem),
    .ram_addr_o  (ram_addr),
    .ram_dout_o  (ram_dout),
    .ram_wr_o    (ram_wr),
    .ram_din_i   (ram_din)
`ifdef MEM_CTRL_IO_FULL_EN
    ,
    .io_full_i   (io_full)
`endif
  );

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    ram_din <= ram[ram_addr[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13;
    ram[12'h020] = 8'hAB;
    ram[12'h200] = 8'h78; ram[12'h201] = 8'h56; ram[12'h202] = 8'h34; ram[12'h203] = 8'h12;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_len = '0; mem_wdata = '0;
`ifdef MEM_CTRL_IO_FULL_EN
    io_full = 1'b0;
`endif
    tick; tick;
    check("rst_wr", ram_wr, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_if_done", if_done, 0);
    check("rst_mem_done", mem_done, 0);
    rst = 1'b0;
    tick;

    // Word fetch at 0x100
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k <= 4) check("fetch_addr", ram_addr, 32'h100 + k - 1);
      check("fetch_stall", stall_if, k != 6);
      check("fetch_done", if_done, k == 6);
      check("fetch_wr", ram_wr, 0);
    end
    check("fetch_data", if_data, 32'h00000013);
    if_req = 1'b0;
    tick;
    check("fetch_idle", if_done, 0);

    // Simultaneous requests: MEM byte load wins
    mem_addr = 32'h20; mem_len = 2'd0; mem_we = 1'b0; mem_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      if (k == 1) check("pri_addr", ram_addr, 32'h20);
      check("pri_stall_if", stall_if, 1);
      check("pri_mem_done", mem_done, k == 3);
      check("pri_if_done", if_done, 0);
    end
    check("pri_rdata", mem_rdata, 32'h000000AB);
    mem_req = 1'b0;
    n = 0;
    while (!if_done && n < 20) begin
      tick;
      if (!if_done) check("pri_stall_wait", stall_if, 1);
      n++;
    end
    check("pri_fetch_done", if_done, 1);
    check("pri_fetch_data", if_data, 32'h12345678);
    if_req = 1'b0;
    tick;

    // Half store 0xBEEF to 0x40; inputs changed after acceptance
    mem_addr = 32'h40; mem_len = 2'd1; mem_we = 1'b1; mem_wdata = 32'h1234BEEF; mem_req = 1'b1;
    tick;
    check("st_wr1", ram_wr, 1);
    check("st_addr1", ram_addr, 32'h40);
    check("st_dout1", ram_dout, 8'hEF);
    mem_addr = 32'h999; mem_wdata = 32'h0; mem_len = 2'd3;
    tick;
    check("st_wr2", ram_wr, 1);
    check("st_addr2", ram_addr, 32'h41);
    check("st_dout2", ram_dout, 8'hBE);
    check("st_done2", mem_done, 0);
    tick;
    check("st_wr3", ram_wr, 0);
    check("st_done3", mem_done, 1);
    check("st_stall3", stall_mem, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;
    check("st_ram40", ram[12'h040], 8'hEF);
    check("st_ram41", ram[12'h041], 8'hBE);
    check("st_ram42", ram[12'h042], 8'h00);

    // Fetch flushed in busy cycle 2
    if_addr = 32'h300; if_req = 1'b1;
    tick;
    tick;
    check("flush_addr2", ram_addr, 32'h301);
    if_req = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      tick;
      if (k == 3) check("flush_idle_addr", ram_addr, 0);
      check("flush_done", if_done, 0);
      check("flush_wr", ram_wr, 0);
    end

    // Reset asserted during a word store
    mem_addr = 32'h80; mem_len = 2'd3; mem_we = 1'b1; mem_wdata = 32'hDDCCBBAA; mem_req = 1'b1;
    tick;
    check("rs_addr1", ram_addr, 32'h80);
    tick;
    check("rs_wr2", ram_wr, 1);
    check("rs_addr2", ram_addr, 32'h81);
    #1 rst = 1'b1;
    #1;
    check("rs_wr_now", ram_wr, 0);
    check("rs_addr_now", ram_addr, 0);
    check("rs_stall_now", stall_mem, 0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      check("rs_no_done", mem_done, 0);
      check("rs_no_wr", ram_wr, 0);
    end
    check("rs_ram80", ram[12'h080], 8'hAA);
    check("rs_ram81", ram[12'h081], 8'h00);
    check("rs_ram82", ram[12'h082], 8'h00);

    // Word load (len 2) wrapping past 0xFFFFFFFF
    mem_addr = 32'hFFFFFFFE; mem_len = 2'd2; mem_we = 1'b0; mem_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      a = 32'hFFFFFFFE + 32'(k - 1);
      if (k <= 4) check("wrap_addr", ram_addr, a);
      check("wrap_done", mem_done, k == 6);
    end
    check("wrap_rdata", mem_rdata, 32'h44332211);
    mem_req = 1'b0;
    tick;

    // Byte store into the IO window
    mem_addr = 32'h30000; mem_len = 2'd0; mem_we = 1'b1; mem_wdata = 32'h0000005A; mem_req = 1'b1;
`ifdef MEM_CTRL_IO_FULL_EN
    io_full = 1'b1;
    #1;
    check("io_stall0", stall_mem, 1);
    for (int k = 1; k <= 5; k++) begin
      tick;
      check("io_blk_wr", ram_wr, 0);
      check("io_blk_stall", stall_mem, 1);
    end
    io_full = 1'b0;
    tick;
`else
    tick;
`endif
    check("io_wr", ram_wr, 1);
    check("io_addr", ram_addr, 32'h30000);
    check("io_dout", ram_dout, 8'h5A);
    tick;
    check("io_done", mem_done, 1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
